// File: rtl/gait_sequencer.sv
// Keyframe gait engine: plays joint-angle tables in a loop with tick-rate ramping.
// Optional GAIT_SEQ_FASTSTEP_EN: steps up to FAST_STEP degrees per tick.
module gait_sequencer #(
    parameter int NUM_JOINTS  = 6,
    parameter int ANGLE_W     = 8,
    parameter int NUM_GAITS   = 4,
    parameter int FRAMES      = 8,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 20,
    parameter int HOME_ANGLE  = 90,
    parameter int ANGLE_MIN   = 0,
    parameter int ANGLE_MAX   = 180,
    parameter int FAST_STEP   = 4
) (
    input  logic                               iClk,
    input  logic                               iRst,
    input  logic                               iCfg_we,
    input  logic [$clog2(NUM_GAITS)-1:0]       iCfg_gait,
    input  logic [$clog2(FRAMES)-1:0]          iCfg_frame,
    input  logic [NUM_JOINTS*ANGLE_W-1:0]      iCfg_angles,
    input  logic                               iCfg_last,
    input  logic [$clog2(NUM_GAITS)-1:0]       iGait_sel,
    input  logic                               iStart,
    input  logic                               iStop,
    output logic [NUM_JOINTS*ANGLE_W-1:0]      oAngles,
    output logic [2:0]                         oState,
    output logic [$clog2(FRAMES)-1:0]          oFrame,
    output logic [$clog2(NUM_GAITS)-1:0]       oGait,
    output logic                               oBusy,
    output logic                               oFrame_done
);

    localparam int GW = $clog2(NUM_GAITS);
    localparam int FW = $clog2(FRAMES);
    localparam int AW = NUM_JOINTS * ANGLE_W;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
`ifdef GAIT_SEQ_FASTSTEP_EN
    localparam int STEP_MAX = FAST_STEP;
`else
    localparam int STEP_MAX = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MOVE   = 3'd2,
        S_DWELL  = 3'd3,
        S_HOMING = 3'd4
    } state_t;

    localparam logic [AW-1:0] HOME_VEC = {NUM_JOINTS{ANGLE_W'(HOME_ANGLE)}};

    state_t state_q, state_d;

    logic [AW:0]    table_mem [0:(1<<(GW+FW))-1];
    logic [AW:0]    rd_entry;
    logic [AW-1:0]  ang_q, tgt_q, goal, ang_step, tgt_load;
    logic [GW-1:0]  gait_q;
    logic [FW-1:0]  frame_q;
    logic [TW-1:0]  tick_cnt;
    logic [DW-1:0]  dwell_cnt;
    logic           last_q, stop_q, done_q;
    logic           tick, all_at;
    logic           load_en, step_en, done_evt, start_evt;
    logic           wrap_evt, adv_evt, home_evt, dwell_clr, dwell_inc;

    function automatic logic [ANGLE_W-1:0] clamp(input logic [ANGLE_W-1:0] a);
        int v;
        v = int'(a);
        if (v < ANGLE_MIN) return ANGLE_W'(ANGLE_MIN);
        if (v > ANGLE_MAX) return ANGLE_W'(ANGLE_MAX);
        return a;
    endfunction

    function automatic logic [ANGLE_W-1:0] step_to(
        input logic [ANGLE_W-1:0] cur,
        input logic [ANGLE_W-1:0] dst
    );
        int c, g, d;
        c = int'(cur);
        g = int'(dst);
        d = (g > c) ? g - c : c - g;
        if (d > STEP_MAX) d = STEP_MAX;
        if (g > c) return ANGLE_W'(c + d);
        if (g < c) return ANGLE_W'(c - d);
        return cur;
    endfunction

    assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
    assign rd_entry = table_mem[{gait_q, frame_q}];
    assign all_at   = (ang_q == goal);

    always_comb begin
        goal     = '0;
        ang_step = '0;
        tgt_load = '0;
        for (int j = 0; j < NUM_JOINTS; j++) begin
            goal[j*ANGLE_W +: ANGLE_W] = (state_q == S_HOMING)
                ? ANGLE_W'(HOME_ANGLE) : tgt_q[j*ANGLE_W +: ANGLE_W];
            ang_step[j*ANGLE_W +: ANGLE_W] = step_to(
                ang_q[j*ANGLE_W +: ANGLE_W], goal[j*ANGLE_W +: ANGLE_W]);
            tgt_load[j*ANGLE_W +: ANGLE_W] =
                clamp(rd_entry[j*ANGLE_W +: ANGLE_W]);
        end
    end

    // Table has no reset; a LOAD in the same cycle as a write sees old data.
    always_ff @(posedge iClk) begin
        if (iCfg_we)
            table_mem[{iCfg_gait, iCfg_frame}] <= {iCfg_last, iCfg_angles};
    end

    always_ff @(posedge iClk) begin
        if (iRst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        step_en   = 1'b0;
        done_evt  = 1'b0;
        start_evt = 1'b0;
        wrap_evt  = 1'b0;
        adv_evt   = 1'b0;
        home_evt  = 1'b0;
        dwell_clr = 1'b0;
        dwell_inc = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    start_evt = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                load_en = 1'b1;
                state_d = S_MOVE;
            end
            S_MOVE: begin
                if (all_at) begin
                    done_evt  = 1'b1;
                    dwell_clr = 1'b1;
                    state_d   = S_DWELL;
                end else if (tick) begin
                    step_en = 1'b1;
                end
            end
            S_DWELL: begin
                if (tick) begin
                    if (dwell_cnt == DW'(DWELL_TICKS - 1)) begin
                        if (stop_q) begin
                            state_d = S_HOMING;
                        end else if (last_q) begin
                            wrap_evt = 1'b1;
                            state_d  = S_LOAD;
                        end else begin
                            adv_evt = 1'b1;
                            state_d = S_LOAD;
                        end
                    end else begin
                        dwell_inc = 1'b1;
                    end
                end
            end
            S_HOMING: begin
                if (all_at) begin
                    done_evt = 1'b1;
                    home_evt = 1'b1;
                    state_d  = S_IDLE;
                end else if (tick) begin
                    step_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ang_q     <= HOME_VEC;
            tgt_q     <= HOME_VEC;
            gait_q    <= '0;
            frame_q   <= '0;
            last_q    <= 1'b0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
            tick_cnt  <= '0;
            dwell_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            done_q   <= done_evt;
            if (start_evt || wrap_evt) begin
                gait_q  <= iGait_sel;
                frame_q <= '0;
            end
            if (adv_evt)
                frame_q <= frame_q + FW'(1);
            if (home_evt) begin
                frame_q <= '0;
                stop_q  <= 1'b0;
            end else if (state_q != S_IDLE && iStop) begin
                stop_q <= 1'b1;
            end
            if (load_en) begin
                tgt_q  <= tgt_load;
                last_q <= rd_entry[AW];
            end
            if (step_en)
                ang_q <= ang_step;
            if (dwell_clr)
                dwell_cnt <= '0;
            else if (dwell_inc)
                dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign oAngles     = ang_q;
    assign oState      = state_q;
    assign oFrame      = frame_q;
    assign oGait       = gait_q;
    assign oBusy       = (state_q != S_IDLE);
    assign oFrame_done = done_q;

endmodule

// File: tb/tb_gait_sequencer.sv
// Directed bench for gait_sequencer with a frame-completion scoreboard.
module tb_gait_sequencer;

    localparam int NJ = 6;
    localparam int AW = 8;

    logic          iClk, iRst, iCfg_we, iCfg_last, iStart, iStop;
    logic [1:0]    iCfg_gait, iGait_sel, oGait;
    logic [2:0]    iCfg_frame, oFrame, oState;
    logic [47:0]   iCfg_angles, oAngles;
    logic          oBusy, oFrame_done;

    typedef struct {
        logic [47:0] ang;
        logic [2:0]  frame;
        logic [1:0]  gait;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_asrt = 0;
    int   n_fail = 0;

    gait_sequencer #(
        .TICK_DIV(4), .DWELL_TICKS(2), .ANGLE_MIN(10)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iCfg_we(iCfg_we),
        .iCfg_gait(iCfg_gait), .iCfg_frame(iCfg_frame),
        .iCfg_angles(iCfg_angles), .iCfg_last(iCfg_last),
        .iGait_sel(iGait_sel), .iStart(iStart), .iStop(iStop),
        .oAngles(oAngles), .oState(oState), .oFrame(oFrame),
        .oGait(oGait), .oBusy(oBusy), .oFrame_done(oFrame_done)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] all_ang(input int a);
        logic [47:0] v;
        for (int j = 0; j < NJ; j++) v[j*AW +: AW] = 8'(a);
        return v;
    endfunction

    function automatic logic [47:0] pack6(input int a0, input int a1,
        input int a2, input int a3, input int a4, input int a5);
        return {8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic int step_exp(input int cur, input int goal);
        int d;
        d = goal - cur;
`ifdef GAIT_SEQ_FASTSTEP_EN
        if (d > 4) d = 4;
        if (d < -4) d = -4;
`else
        if (d > 1) d = 1;
        if (d < -1) d = -1;
`endif
        return cur + d;
    endfunction

    function automatic exp_t mk(input logic [47:0] a, input int f,
                                input int g);
        exp_t e;
        e.ang = a;
        e.frame = 3'(f);
        e.gait = 2'(g);
        return e;
    endfunction

    task automatic write_frame(input int g, input int f,
                               input logic [47:0] a, input logic last);
        iCfg_we     = 1'b1;
        iCfg_gait   = 2'(g);
        iCfg_frame  = 3'(f);
        iCfg_angles = a;
        iCfg_last   = last;
        @(negedge iClk);
        iCfg_we     = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc,
                              input string tag);
        int k = 0;
        while (oState !== s && k < maxc) begin
            @(negedge iClk);
            k++;
        end
        chk(tag, oState, s);
    endtask

    task automatic wait_change(input int maxc, input string tag,
                               input logic [47:0] exp);
        logic [47:0] prev;
        int k = 0;
        prev = oAngles;
        while (oAngles === prev && k < maxc) begin
            @(negedge iClk);
            k++;
        end
        chk(tag, oAngles, exp);
    endtask

    task automatic ramp_check(input int from, input int to,
                              input string tag);
        int cur, nxt;
        cur = from;
        while (cur != to) begin
            nxt = step_exp(cur, to);
            wait_change(40, tag, all_ang(nxt));
            cur = nxt;
        end
    endtask

    always @(negedge iClk) begin
        if (!iRst && oFrame_done === 1'b1) begin
            chk("sb_pulse_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("sb_angles", oAngles, mon_e.ang);
                chk("sb_frame", oFrame, mon_e.frame);
                chk("sb_gait", oGait, mon_e.gait);
            end
        end
    end

    initial begin
        iRst = 1'b1; iCfg_we = 1'b0; iCfg_gait = '0; iCfg_frame = '0;
        iCfg_angles = '0; iCfg_last = 1'b0; iGait_sel = '0;
        iStart = 1'b0; iStop = 1'b0;
        repeat (3) @(negedge iClk);
        chk("rst_angles", oAngles, all_ang(90));
        chk("rst_state", oState, 3'd0);
        chk("rst_busy", oBusy, 1'b0);
        chk("rst_done", oFrame_done, 1'b0);
        chk("rst_frame", oFrame, 3'd0);
        chk("rst_gait", oGait, 2'd0);
        iRst = 1'b0;
        @(negedge iClk);

        write_frame(0, 0, all_ang(92), 1'b0);
        write_frame(0, 1, all_ang(90), 1'b1);
        write_frame(1, 0, pack6(95, 85, 200, 0, 90, 90), 1'b1);
        write_frame(2, 0, all_ang(100), 1'b1);
        chk("idle_after_cfg", oState, 3'd0);

        // Run 1: gait 0 loop, gait change at the wrap, then stop.
        sbq.push_back(mk(all_ang(92), 0, 0));
        sbq.push_back(mk(all_ang(90), 1, 0));
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        wait_state(3'd1, 10, "r1_load0");
        chk("r1_busy", oBusy, 1'b1);
        iGait_sel = 2'd1;
        ramp_check(90, 92, "r1_ramp_up");
        wait_state(3'd3, 20, "r1_dwell0");
        wait_state(3'd1, 40, "r1_load1");
        chk("r1_frame1", oFrame, 3'd1);
        chk("r1_gait_held", oGait, 2'd0);
        ramp_check(92, 90, "r1_ramp_dn");
        wait_state(3'd3, 20, "r1_dwell1");
        sbq.push_back(mk(pack6(95, 85, 180, 10, 90, 90), 0, 1));
        wait_state(3'd1, 40, "r1_wrap_load");
        chk("r1_wrap_frame", oFrame, 3'd0);
        chk("r1_wrap_gait", oGait, 2'd1);
        wait_state(3'd3, 1000, "r1_clamp_dwell");
        chk("r1_clamp_pose", oAngles, pack6(95, 85, 180, 10, 90, 90));

        // Same-cycle write to the entry being loaded returns old data.
        iGait_sel = 2'd2;
        sbq.push_back(mk(all_ang(100), 0, 2));
        wait_state(3'd1, 40, "r1_load_g2");
        chk("r1_gait2", oGait, 2'd2);
        write_frame(2, 0, all_ang(120), 1'b1);
        wait_state(3'd3, 1000, "r1_g2_dwell");
        chk("r1_rbw_pose", oAngles, all_ang(100));
        sbq.push_back(mk(all_ang(90), 0, 2));
        iStop = 1'b1;
        @(negedge iClk);
        iStop = 1'b0;
        wait_state(3'd4, 40, "r1_homing");
        wait_state(3'd0, 200, "r1_idle");
        chk("r1_idle_busy", oBusy, 1'b0);
        chk("r1_idle_angles", oAngles, all_ang(90));
        chk("r1_idle_frame", oFrame, 3'd0);

        // Run 2: stop mid-move toward 92.
        iGait_sel = 2'd0;
        sbq.push_back(mk(all_ang(92), 0, 0));
        sbq.push_back(mk(all_ang(90), 0, 0));
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        wait_state(3'd1, 10, "r2_load");
        wait_change(40, "r2_first_step", all_ang(step_exp(90, 92)));
        iStop = 1'b1;
        @(negedge iClk);
        iStop = 1'b0;
        wait_state(3'd3, 40, "r2_dwell");
        chk("r2_at_target", oAngles, all_ang(92));
        wait_state(3'd4, 40, "r2_homing");
        ramp_check(92, 90, "r2_home_ramp");
        wait_state(3'd0, 20, "r2_idle");
        chk("r2_busy", oBusy, 1'b0);

        // Run 3: start and stop together, start wins; then reset mid-move.
        sbq.push_back(mk(all_ang(92), 0, 0));
        iStart = 1'b1;
        iStop  = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        iStop  = 1'b0;
        wait_state(3'd1, 10, "r3_load");
        ramp_check(90, 92, "r3_ramp_up");
        wait_state(3'd3, 20, "r3_dwell");
        wait_state(3'd1, 40, "r3_no_stop_load");
        chk("r3_frame1", oFrame, 3'd1);
        wait_change(40, "r3_step_dn", all_ang(step_exp(92, 90)));
        iRst = 1'b1;
        @(negedge iClk);
        iRst = 1'b0;
        chk("r3_rst_angles", oAngles, all_ang(90));
        chk("r3_rst_state", oState, 3'd0);
        chk("r3_rst_busy", oBusy, 1'b0);
        chk("r3_rst_frame", oFrame, 3'd0);
        chk("r3_rst_gait", oGait, 2'd0);
        chk("r3_rst_done", oFrame_done, 1'b0);
        repeat (20) @(negedge iClk);
        chk("r3_stay_idle", oState, 3'd0);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/gait_sequencer.md
Name: gait_sequencer

Overview:
Parametrised keyframe gait engine for the biped joint chain. It holds a writable table of joint-angle keyframes for several gaits. It plays the selected gait in a loop, ramping every joint toward each keyframe at a fixed tick rate and dwelling once all joints arrive. It supports a graceful stop with return to a home pose. Outputs are packed joint angles that feed the downstream per-joint angle-to-PWM path.

Parameters:
NUM_JOINTS, 6, number of servo joints
ANGLE_W, 8, bits per joint angle (degrees)
NUM_GAITS, 4, number of gait programs in the table
FRAMES, 8, keyframes per gait (power of 2)
TICK_DIV, 50000, clocks per motion tick (1 ms at 50 MHz)
DWELL_TICKS, 20, ticks held after a frame is reached
HOME_ANGLE, 90, reset/home angle for all joints
ANGLE_MIN, 0, lower clamp
ANGLE_MAX, 180, upper clamp
FAST_STEP, 4, degrees per tick when GAIT_SEQ_FASTSTEP_EN is defined

Ports:
iClk  in  1  system clock
iRst  in  1  reset, synchronous, active-high
iCfg_we  in  1  table write strobe
iCfg_gait  in  clog2(NUM_GAITS)  gait index for write
iCfg_frame  in  clog2(FRAMES)  frame index for write
iCfg_angles  in  NUM_JOINTS*ANGLE_W  packed targets; joint 0 = LSBs
iCfg_last  in  1  marks frame as last of its gait
iGait_sel  in  clog2(NUM_GAITS)  requested gait
iStart  in  1  start request (level sampled)
iStop  in  1  stop request (level sampled)
oAngles  out  NUM_JOINTS*ANGLE_W  current packed joint angles
oState  out  3  FSM state code
oFrame  out  clog2(FRAMES)  current frame index
oGait  out  clog2(NUM_GAITS)  gait being played
oBusy  out  1  high in any state except IDLE
oFrame_done  out  1  one-cycle pulse when all joints reach target

Behaviour:
- Reset (iRst high at an iClk edge): every joint angle = HOME_ANGLE; state IDLE (0); oFrame = 0; oGait = 0; oBusy = 0; oFrame_done = 0; stop_pending = 0; tick counter = 0. Table contents are not reset.
- Tick: counter runs from reset regardless of state. It asserts tick for one cycle when the count reaches TICK_DIV-1, then wraps to 0.
- State codes: IDLE = 0, LOAD = 1, MOVE = 2, DWELL = 3, HOMING = 4.
- IDLE: iStart = 1 latches iGait_sel into oGait, sets frame = 0, goes to LOAD. iStop is ignored. If iStart and iStop are both high, start wins and stop_pending stays 0.
- LOAD: one cycle. Synchronous table read of (oGait, oFrame). Each target is clamped to [ANGLE_MIN, ANGLE_MAX]. Next state is MOVE.
- MOVE: on each tick, every joint with angle != target steps 1 toward it. No overshoot. When all joints equal their targets, pulse oFrame_done for one cycle and go to DWELL. A frame identical to the current pose completes on the first MOVE cycle without waiting for a tick.
- DWELL: count DWELL_TICKS ticks, then:
  - stop_pending set → HOMING.
  - current frame has last = 1 → frame = 0, re-sample iGait_sel into oGait, go to LOAD.
  - otherwise → frame + 1, go to LOAD.
  - Gait changes take effect only at this wrap point.
- Frame index: the wrap from FRAMES-1 to 0 happens even if last is not set.
- HOMING: targets = HOME_ANGLE for all joints, stepping as in MOVE. When all joints are home, pulse oFrame_done, clear stop_pending, go to IDLE, frame = 0.
- iStop while busy: sets stop_pending, which is sticky. The current frame completes its move and dwell before homing. iStart while busy is ignored.
- Table writes are accepted in any state. A write to the entry being read in the same LOAD cycle returns the old data (read-before-write).
- Reset mid-operation: next cycle all outputs are at their reset values.

Optional Feature:
GAIT_SEQ_FASTSTEP_EN
- Defined: each joint steps by min(|target - angle|, FAST_STEP) per tick.
- Undefined: step is exactly 1 per tick. FAST_STEP is unused.

Test Plan:
- Reset with TICK_DIV = 4, DWELL_TICKS = 2 → oAngles all 90, oState = 0, oBusy = 0, oFrame_done = 0.
- Gait 0 frame 0 = all 92 (last = 0), frame 1 = all 90 (last = 1); assert iStart → angles 91 then 92 on successive ticks; oFrame_done pulses once; after 2 ticks dwell, frame 1 loads; angles return to 90; sequence wraps to frame 0.
- Frame 0 joint 2 = 200, joint 3 = 0 with ANGLE_MIN = 10 → those joints settle at 180 and 10 respectively.
- iGait_sel changed 0 → 1 during frame 0 of a 2-frame gait → oGait stays 0 through frame 1, becomes 1 at the wrap; LOAD reads gait 1 frame 0.
- iStop pulsed mid-MOVE toward 92 → reaches 92, dwells 2 ticks, ramps back to 90, oState = 0, oBusy = 0.
- iRst asserted mid-MOVE with angles at 91 → next cycle all angles 90, IDLE; with GAIT_SEQ_FASTSTEP_EN, move 90 → 100 goes 94, 98, 100.
